// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Brief    : RV32I(+C,+M) decoder feeding a DEPTH-entry queue of decoded ops.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int ENABLE_C = 1,
    parameter int ENABLE_M = 1,
    parameter int DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc,
    output logic [5:0]  out_op,
    output logic        out_alt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_compressed,
    output logic        out_illegal,
    output logic [31:0] stall_cycles
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [5:0]  op;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        compressed;
        logic        illegal;
    } entry_t;

    logic [15:0] w_c;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [4:0]  w_crd, w_crs2, w_crdp, w_crs1p;
    logic [31:0] w_cimm6, w_cimm_j, w_cimm_b, w_cimm_lw, w_cimm_4spn;
    logic [31:0] w_cimm_16sp, w_cimm_lui, w_cimm_lwsp, w_cimm_swsp, w_cshamt;

    assign w_c     = in_instr[15:0];
    assign w_f3    = in_instr[14:12];
    assign w_f7    = in_instr[31:25];
    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    assign w_crd       = w_c[11:7];
    assign w_crs2      = w_c[6:2];
    assign w_crdp      = {2'b01, w_c[4:2]};
    assign w_crs1p     = {2'b01, w_c[9:7]};
    assign w_cimm6     = {{26{w_c[12]}}, w_c[12], w_c[6:2]};
    assign w_cimm_j    = {{20{w_c[12]}}, w_c[12], w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2], w_c[11], w_c[5:3], 1'b0};
    assign w_cimm_b    = {{23{w_c[12]}}, w_c[12], w_c[6:5], w_c[2], w_c[11:10], w_c[4:3], 1'b0};
    assign w_cimm_lw   = {25'b0, w_c[5], w_c[12:10], w_c[6], 2'b0};
    assign w_cimm_4spn = {22'b0, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b0};
    assign w_cimm_16sp = {{22{w_c[12]}}, w_c[12], w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0};
    assign w_cimm_lui  = {{14{w_c[12]}}, w_c[12], w_c[6:2], 12'b0};
    assign w_cimm_lwsp = {24'b0, w_c[3:2], w_c[12], w_c[6:4], 2'b0};
    assign w_cimm_swsp = {24'b0, w_c[8:7], w_c[12:9], 2'b0};
    assign w_cshamt    = {26'b0, w_c[12], w_c[6:2]};

    logic [2:0]  w_cls, w_sub;
    logic        w_alt, w_ill, w_comp;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm;
    entry_t      w_entry;

    always_comb begin
        w_cls = '0; w_sub = '0; w_alt = 1'b0; w_ill = 1'b0;
        w_rd = '0; w_rs1 = '0; w_rs2 = '0; w_imm = '0;
        w_entry = '0;
        w_comp = (in_instr[1:0] != 2'b11);
        if (w_comp) begin
            if (ENABLE_C == 0) begin
                w_ill = 1'b1;
            end else begin
                case ({w_c[1:0], w_c[15:13]})
                    5'b00_000: begin w_cls = 3'd1; w_rd = w_crdp; w_rs1 = 5'd2; w_imm = w_cimm_4spn; w_ill = (w_cimm_4spn == '0); end
                    5'b00_010: begin w_cls = 3'd3; w_sub = 3'd2; w_rd = w_crdp; w_rs1 = w_crs1p; w_imm = w_cimm_lw; end
                    5'b00_110: begin w_cls = 3'd4; w_sub = 3'd2; w_rs1 = w_crs1p; w_rs2 = w_crdp; w_imm = w_cimm_lw; end
                    5'b01_000: begin w_cls = 3'd1; w_rd = w_crd; w_rs1 = w_crd; w_imm = w_cimm6; end
                    5'b01_001: begin w_cls = 3'd6; w_rd = 5'd1; w_imm = w_cimm_j; end
                    5'b01_010: begin w_cls = 3'd1; w_rd = w_crd; w_imm = w_cimm6; end
                    5'b01_011: begin
                        if (w_crd == 5'd2) begin
                            w_cls = 3'd1; w_rd = 5'd2; w_rs1 = 5'd2; w_imm = w_cimm_16sp; w_ill = (w_cimm_16sp == '0);
                        end else begin
                            w_cls = 3'd6; w_sub = 3'd2; w_rd = w_crd; w_imm = w_cimm_lui; w_ill = (w_cimm_lui == '0);
                        end
                    end
                    5'b01_100: begin
                        w_rd = w_crs1p; w_rs1 = w_crs1p; w_cls = 3'd1;
                        case (w_c[11:10])
                            2'b00, 2'b01: begin w_sub = 3'd5; w_alt = w_c[10]; w_imm = w_cshamt; w_ill = w_c[12]; end
                            2'b10:        begin w_sub = 3'd7; w_imm = w_cimm6; end
                            default: begin
                                w_cls = 3'd0; w_rs2 = w_crdp; w_ill = w_c[12];
                                case (w_c[6:5])
                                    2'b00:   begin w_sub = 3'd0; w_alt = 1'b1; end
                                    2'b01:   w_sub = 3'd4;
                                    2'b10:   w_sub = 3'd6;
                                    default: w_sub = 3'd7;
                                endcase
                            end
                        endcase
                    end
                    5'b01_101: begin w_cls = 3'd6; w_imm = w_cimm_j; end
                    5'b01_110, 5'b01_111: begin w_cls = 3'd5; w_sub = {2'b00, w_c[13]}; w_rs1 = w_crs1p; w_imm = w_cimm_b; end
                    5'b10_000: begin w_cls = 3'd1; w_sub = 3'd1; w_rd = w_crd; w_rs1 = w_crd; w_imm = w_cshamt; w_ill = w_c[12]; end
                    5'b10_010: begin w_cls = 3'd3; w_sub = 3'd2; w_rd = w_crd; w_rs1 = 5'd2; w_imm = w_cimm_lwsp; w_ill = (w_crd == '0); end
                    5'b10_100: begin
                        if (!w_c[12]) begin
                            if (w_crs2 == '0) begin w_cls = 3'd6; w_sub = 3'd1; w_rs1 = w_crd; w_ill = (w_crd == '0); end
                            else              begin w_cls = 3'd0; w_rd = w_crd; w_rs2 = w_crs2; end
                        end else if (w_crs2 == '0) begin
                            if (w_crd == '0) begin w_cls = 3'd7; w_sub = 3'd1; end
                            else             begin w_cls = 3'd6; w_sub = 3'd1; w_rd = 5'd1; w_rs1 = w_crd; end
                        end else begin
                            w_cls = 3'd0; w_rd = w_crd; w_rs1 = w_crd; w_rs2 = w_crs2;
                        end
                    end
                    5'b10_110: begin w_cls = 3'd4; w_sub = 3'd2; w_rs1 = 5'd2; w_rs2 = w_crs2; w_imm = w_cimm_swsp; end
                    default:   w_ill = 1'b1;
                endcase
            end
        end else begin
            case (in_instr[6:0])
                7'b0110011: begin
                    w_rd = in_instr[11:7]; w_rs1 = in_instr[19:15]; w_rs2 = in_instr[24:20]; w_sub = w_f3;
                    if (w_f7 == 7'b0000000)                                        w_cls = 3'd0;
                    else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) w_alt = 1'b1;
                    else if (w_f7 == 7'b0000001 && ENABLE_M != 0)                  w_cls = 3'd2;
                    else                                                           w_ill = 1'b1;
                end
                7'b0010011: begin
                    w_cls = 3'd1; w_sub = w_f3; w_rd = in_instr[11:7]; w_rs1 = in_instr[19:15]; w_imm = w_imm_i;
                    // shifts carry only the shift amount, the upper field selects SRAI
                    if (w_f3 == 3'd1) begin
                        w_imm = {27'b0, in_instr[24:20]}; w_ill = (w_f7 != 7'b0000000);
                    end else if (w_f3 == 3'd5) begin
                        w_imm = {27'b0, in_instr[24:20]}; w_alt = in_instr[30];
                        w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                end
                7'b0000011: begin w_cls = 3'd3; w_sub = w_f3; w_rd = in_instr[11:7]; w_rs1 = in_instr[19:15]; w_imm = w_imm_i;
                                  w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7); end
                7'b0100011: begin w_cls = 3'd4; w_sub = w_f3; w_rs1 = in_instr[19:15]; w_rs2 = in_instr[24:20]; w_imm = w_imm_s;
                                  w_ill = (w_f3 > 3'd2); end
                7'b1100011: begin w_cls = 3'd5; w_sub = w_f3; w_rs1 = in_instr[19:15]; w_rs2 = in_instr[24:20]; w_imm = w_imm_b;
                                  w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3); end
                7'b1101111: begin w_cls = 3'd6; w_rd = in_instr[11:7]; w_imm = w_imm_j; end
                7'b1100111: begin w_cls = 3'd6; w_sub = 3'd1; w_rd = in_instr[11:7]; w_rs1 = in_instr[19:15]; w_imm = w_imm_i;
                                  w_ill = (w_f3 != 3'd0); end
                7'b0110111: begin w_cls = 3'd6; w_sub = 3'd2; w_rd = in_instr[11:7]; w_imm = w_imm_u; end
                7'b0010111: begin w_cls = 3'd6; w_sub = 3'd3; w_rd = in_instr[11:7]; w_imm = w_imm_u; end
                7'b1110011: begin
                    w_cls = 3'd7;
                    if (w_f3 == 3'd0) begin
                        if (in_instr == 32'h0000_0073)      w_sub = 3'd0;
                        else if (in_instr == 32'h0010_0073) w_sub = 3'd1;
                        else                                w_ill = 1'b1;
                    end else if (w_f3 == 3'd4) begin
                        w_ill = 1'b1;
                    end else begin
                        // register and immediate CSR forms share a sub-code; rs1 carries zimm
                        w_sub = {1'b1, w_f3[1:0]}; w_rd = in_instr[11:7]; w_rs1 = in_instr[19:15];
                        w_imm = {20'b0, in_instr[31:20]};
                    end
                end
                default: w_ill = 1'b1;
            endcase
        end
        if (w_ill) begin
            w_cls = '0; w_sub = '0; w_alt = 1'b0; w_rd = '0; w_rs1 = '0; w_rs2 = '0; w_imm = '0;
        end
        w_entry.pc         = in_pc;
        w_entry.next_pc    = in_pc + (w_comp ? 32'd2 : 32'd4);
        w_entry.op         = {w_cls, w_sub};
        w_entry.alt        = w_alt;
        w_entry.rd         = w_rd;
        w_entry.rs1        = w_rs1;
        w_entry.rs2        = w_rs2;
        w_entry.imm        = w_imm;
        w_entry.compressed = w_comp;
        w_entry.illegal    = w_ill;
    end

    entry_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd, r_wr;
    logic [c_PTR_W:0]   r_count;
    logic               r_up;
    logic [31:0]        r_stall;
    logic               w_push, w_pop;
    entry_t             w_head;

    assign in_ready  = r_up && (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_up    <= 1'b0;
            r_stall <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_up <= 1'b1;
            if (out_valid && !out_ready && r_stall != 32'hFFFF_FFFF) r_stall <= r_stall + 32'd1;
            if (flush) begin
                r_count <= '0;
                r_rd    <= '0;
                r_wr    <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr] <= w_entry;
                    r_wr        <= r_wr + 1'b1;
                end
                if (w_pop) r_rd <= r_rd + 1'b1;
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            end
        end
    end

    assign out_pc         = w_head.pc;
    assign out_next_pc    = w_head.next_pc;
    assign out_op         = w_head.op;
    assign out_alt        = w_head.alt;
    assign out_rd         = w_head.rd;
    assign out_rs1        = w_head.rs1;
    assign out_rs2        = w_head.rs2;
    assign out_imm        = w_head.imm;
    assign out_compressed = w_head.compressed;
    assign out_illegal    = w_head.illegal;
    assign stall_cycles   = r_stall;

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised RV32I decode stage with an optional C and M extension and a DEPTH-entry queue of already-decoded instructions.
- Sits between the fetcher and the executor. Each fetched instruction is decoded combinationally on entry and then stored in the queue.
- Replaces per-instruction flag outputs with a compact op code. Adds back-pressure buffering, flush, illegal-instruction reporting, next-pc generation and a stall counter.

Parameters:
- ENABLE_C, 1, 1 = decode RVC quadrants 00/01/10; 0 = any instr[1:0] != 2'b11 is illegal.
- ENABLE_M, 1, 1 = decode MUL/DIV/REM; 0 = funct7 0000001 on the OP opcode is illegal.
- DEPTH, 2, number of queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard all queued entries and any same-cycle input.
- in_valid  in  1  fetcher presents an instruction.
- in_ready  out  1  queue can accept an instruction this cycle.
- in_instr  in  32  instruction word; compressed occupies [15:0].
- in_pc  in  32  address of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  executor consumes the head entry.
- out_pc  out  32  pc of the head entry.
- out_next_pc  out  32  out_pc+2 if compressed, else out_pc+4, modulo 2^32.
- out_op  out  6  {class[2:0], sub[2:0]}, encoding below.
- out_alt  out  1  SUB/SRA/SRAI select.
- out_rd, out_rs1, out_rs2  out  5 each  register indices after RVC expansion.
- out_imm  out  32  sign- or zero-extended immediate; 0 if none.
- out_compressed  out  1  head entry was 16-bit.
- out_illegal  out  1  head entry failed to decode.
- stall_cycles  out  32  saturating count of cycles with out_valid && !out_ready.

Behaviour:
- Op classes and sub-codes:
  - class 0 ALU reg, sub = funct3.
  - class 1 ALU imm, sub = funct3.
  - class 2 MULDIV, sub = funct3.
  - class 3 LOAD, sub = funct3.
  - class 4 STORE, sub = funct3.
  - class 5 BRANCH, sub = funct3.
  - class 6 UPPER/JUMP: sub 0 jal, 1 jalr, 2 lui, 3 auipc.
  - class 7 SYSTEM: sub 0 ecall, 1 ebreak, 5 csrrw(i), 6 csrrs(i), 7 csrrc(i).
- RVC expansion:
  - Each compressed instruction maps to its RV32 equivalent op, registers and immediate.
  - rd/rs1/rs2 of x0 are made explicit: c.li rs1=0; c.j rd=0; c.jal/c.jalr rd=1; c.beqz/c.bnez rs2=0.
  - Expanded rs1/rs2 stay 0 for formats with no source register.
- Illegal instructions: unsupported opcode/funct, 16'h0000, reserved RVC encodings (c.addi4spn imm 0, c.lui/c.addi16sp imm 0, c.lwsp rd 0), and extensions disabled by parameter.
  - Illegal entries are enqueued with out_illegal=1, out_op=0, rd=rs1=rs2=0, imm=0.
  - out_pc and out_compressed still reflect the instruction.
- Queue:
  - Circular buffer with rd/wr pointers and a count of width log2(DEPTH)+1.
  - Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH) and out of reset. A pop in the same cycle does not raise in_ready when full (no combinational ready path).
  - out_valid = (count != 0). All out_* are driven from the head entry register, with no combinational path from in_*.
  - Latency: an instruction accepted in cycle N appears at the head no earlier than cycle N+1.
  - Push and pop in the same cycle on a non-empty, non-full queue leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
- Flush:
  - On a flush cycle, count, rd and wr return to 0 at the next edge; out_valid=0 the next cycle.
  - Input presented in the flush cycle is dropped.
  - A pop in the flush cycle is still considered consumed.
  - stall_cycles is unaffected by flush.
- stall_cycles increments when out_valid && !out_ready and holds at 32'hFFFF_FFFF.
- Reset (asynchronous, when reset=0):
  - count, pointers, stall_cycles and all entry storage go to 0.
  - out_valid=0, in_ready=0, and every out_* reads 0.
  - in_ready rises on the first posedge after reset deasserts.
- Outputs while out_valid=0 are don't-care to the consumer but must be stable (hold the last head-slot value).

Test Plan:
- Reset deassert, in_pc=0x100, in_instr=0x00500093, out_ready=1 -> next cycle:
  - out_valid=1, op={1,0}, rd=1, rs1=0, imm=5.
  - compressed=0, next_pc=0x104.
- ENABLE_C=1, in_instr=0x00004505, in_pc=0x200 ->
  - op={1,0}, rd=10, rs1=0, imm=1.
  - compressed=1, next_pc=0x202.
- in_instr=0x022081B3 with ENABLE_M=1 -> op={2,0}, rd=3, rs1=1, rs2=2.
  - Same instruction with ENABLE_M=0 -> out_illegal=1, op=0.
  - in_instr=0x00000000 -> out_illegal=1, compressed=1.
- DEPTH=2, out_ready=0, three back-to-back pushes ->
  - in_ready=0 after the second accept; the third is held and out_valid stays 1.
  - stall_cycles increments every cycle.
  - After out_ready=1, instructions emerge in order, one per cycle.
- Queue holding 2 entries, flush=1 together with in_valid=1 -> next cycle:
  - out_valid=0, the flushed input is not enqueued.
  - in_ready=1, count=0.
- reset asserted mid-stream with the queue non-empty -> same cycle:
  - out_valid=0, in_ready=0, stall_cycles=0.
  - After release, no stale entries appear.
